ext_mem_arbiter: RTL and testbench
==================================

Name: ext_mem_arbiter

Overview:
- Sequences the single external memory port and shares it between two requesters: instruction-side (imem) and data-side (dmem) cache refill/write-through paths.
- Grants one transaction at a time. dmem has fixed priority, with a starvation guard for imem.
- Drives registered address, read/write enables and write data to external memory, and returns read data with a one-cycle ack pulse.

Parameters:
- WORD_SIZE, 32, data width of all data buses
- STARVE_LIMIT, 4, consecutive dmem grants while imem is waiting before imem is forced next; 0 = strict dmem priority
- TIMEOUT_CYCLES, 64, op-state cycles without mem_ready before abort (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- imem_req  in  1  imem transaction request; held until imem_ack
- imem_addr  in  32  imem address
- imem_rdata  out  WORD_SIZE  read data, valid while imem_ack=1
- imem_ack  out  1  one-cycle completion pulse
- dmem_req  in  1  dmem transaction request; held until dmem_ack
- dmem_we  in  1  1 = write, 0 = read
- dmem_addr  in  32  dmem address
- dmem_wdata  in  WORD_SIZE  dmem write data
- dmem_rdata  out  WORD_SIZE  read data, valid while dmem_ack=1
- dmem_ack  out  1  one-cycle completion pulse
- mem_addr  out  32  external address
- en_ext_mem_re  out  1  external read enable
- en_ext_mem_wr  out  1  external write enable
- data_in  out  WORD_SIZE  write data to external memory
- data_out  in  WORD_SIZE  read data from external memory
- mem_ready  in  1  external completion
- busy  out  1  1 when the state is not IDLE
- err  out  1  one-cycle pulse alongside an ack on timeout abort

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - All outputs 0.
  - Starvation and timeout counters 0.
  - A transaction in flight at reset is dropped; no ack is issued.
- States: IDLE, IMEM_OP, DMEM_OP.
- IDLE arbitration, evaluated at each posedge:
  - A requester whose ack is high this cycle is ignored, so a req still high in its ack cycle does not restart.
  - Only dmem_req: go to DMEM_OP.
  - Only imem_req: go to IMEM_OP.
  - Both requesting: go to DMEM_OP, unless starve_cnt == STARVE_LIMIT and STARVE_LIMIT != 0, in which case go to IMEM_OP.
  - Neither requesting: stay in IDLE.
- Starvation counter:
  - Increments on each DMEM_OP grant made while imem_req=1; saturates at STARVE_LIMIT.
  - Clears on an IMEM_OP grant.
- On entering an op state (same edge), registered outputs load:
  - mem_addr = requester's address.
  - IMEM_OP: en_ext_mem_re=1, en_ext_mem_wr=0.
  - DMEM_OP: en_ext_mem_re=~dmem_we, en_ext_mem_wr=dmem_we, data_in=dmem_wdata.
  - Requester inputs are sampled at grant; later changes are ignored.
- Op state:
  - Hold all external outputs stable until mem_ready=1 is sampled.
  - On that edge: go to IDLE, clear en_ext_mem_re, en_ext_mem_wr, mem_addr and data_in to 0, and pulse the requester's ack for one cycle.
  - rdata = data_out on a read; rdata = 0 on a dmem write.
- rdata holds its value until the next ack of that requester.
- Minimum latency, request seen at edge N:
  - Enables high N..N+1.
  - If mem_ready is sampled at N+1, ack is high in cycle N+1..N+2.
  - Back-to-back transactions have a mandatory IDLE (ack) cycle between them.
- mem_ready is ignored in IDLE.
- imem_ack and dmem_ack are never high in the same cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entering an op state and increments each op-state cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, drop enables, pulse ack with rdata=0 and err=1 for one cycle.
  - If mem_ready and the timeout coincide, mem_ready wins (normal completion, err=0).
- Not defined: the op state waits indefinitely, err is tied 0, and no counter is instantiated.

Test Plan:
- Reset: hold rst=0 with imem_req=1 -> all outputs 0, busy=0. Release -> next edge en_ext_mem_re=1, mem_addr=imem_addr=0x0000_0100.
- imem read with mem_ready after 3 cycles, data_out=0xDEADBEEF -> imem_ack high exactly 1 cycle, imem_rdata=0xDEADBEEF, dmem_ack=0.
- Simultaneous req (dmem write addr 0x2000, wdata 0x12345678; imem addr 0x40):
  - dmem is granted first: en_ext_mem_wr=1, data_in=0x12345678.
  - imem is granted after dmem_ack plus one IDLE cycle.
- Starvation, STARVE_LIMIT=4: dmem_req and imem_req held continuously -> grant order D,D,D,D,I,D...
- Reset mid-op: drop rst during DMEM_OP -> enables 0 immediately, no ack. After release with no requests, state stays IDLE.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready never asserted -> ack plus err pulse after 8 op-state cycles, rdata=0. Repeat with mem_ready arriving on cycle 8 -> err=0.

Source files
------------

// File: rtl/ext_mem_arbiter_if.sv
// Bus bundle between the arbiter, its imem/dmem requesters and external memory.
// Modports: slave = arbiter side, master = requester/memory side.
interface ext_mem_arbiter_if #(
  parameter int WORD_SIZE = 32
);
  logic                 imem_req;
  logic [31:0]          imem_addr;
  logic [WORD_SIZE-1:0] imem_rdata;
  logic                 imem_ack;
  logic                 dmem_req;
  logic                 dmem_we;
  logic [31:0]          dmem_addr;
  logic [WORD_SIZE-1:0] dmem_wdata;
  logic [WORD_SIZE-1:0] dmem_rdata;
  logic                 dmem_ack;
  logic [31:0]          mem_addr;
  logic                 en_ext_mem_re;
  logic                 en_ext_mem_wr;
  logic [WORD_SIZE-1:0] data_in;
  logic [WORD_SIZE-1:0] data_out;
  logic                 mem_ready;
  logic                 busy;
  logic                 err;

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ack,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack,
    output mem_addr, en_ext_mem_re, en_ext_mem_wr, data_in,
    input  data_out, mem_ready,
    output busy, err
  );

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack,
    input  mem_addr, en_ext_mem_re, en_ext_mem_wr, data_in,
    output data_out, mem_ready,
    input  busy, err
  );
endinterface

// File: rtl/ext_mem_arbiter.sv
// Shares one external memory port between imem and dmem (dmem priority,
// starvation guard for imem). Ports: clk, rst (async, active-low), bus
// (ext_mem_arbiter_if.slave: req/ack/rdata per requester, external
// addr/enables/data, busy, err). Optional ARB_TIMEOUT_EN adds op timeout.
module ext_mem_arbiter #(
  parameter int WORD_SIZE      = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              rst,
  ext_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IMEM_OP = 2'd1,
    DMEM_OP = 2'd2
  } state_t;

  localparam int SW =
    (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  state_t               state_q, state_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic [31:0]          addr_q, addr_d;
  logic                 re_q, re_d;
  logic                 wr_q, wr_d;
  logic [WORD_SIZE-1:0] din_q, din_d;
  logic [WORD_SIZE-1:0] irdata_q, irdata_d;
  logic [WORD_SIZE-1:0] drdata_q, drdata_d;
  logic                 iack_q, iack_d;
  logic                 dack_q, dack_d;

  logic ireq, dreq, starve_hit;
  logic gnt_i, gnt_d;
  logic in_op, done, abort, to_hit;

  // A requester still holding req in its ack cycle must not restart.
  assign ireq = bus.imem_req & ~iack_q;
  assign dreq = bus.dmem_req & ~dack_q;

  assign starve_hit = (STARVE_LIMIT != 0) && (starve_q == SLIM);
  assign gnt_i = ireq & (~dreq | starve_hit);
  assign gnt_d = dreq & ~gnt_i;

  assign in_op = (state_q != IDLE);
  assign done  = in_op & bus.mem_ready;
  assign abort = in_op & to_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q;

  // mem_ready on the final cycle wins over the abort.
  assign to_hit = ~bus.mem_ready &&
    (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tcnt_d = '0;
    if (in_op && !bus.mem_ready) tcnt_d = tcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= abort;
    end
  end

  assign bus.err = err_q;
`else
  // No timeout in this build: the op state waits for mem_ready forever.
  assign to_hit  = (TIMEOUT_CYCLES < 0);
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    re_d     = re_q;
    wr_d     = wr_q;
    din_d    = din_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    iack_d   = 1'b0;
    dack_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt_d: begin
            state_d = DMEM_OP;
            addr_d  = bus.dmem_addr;
            re_d    = ~bus.dmem_we;
            wr_d    = bus.dmem_we;
            din_d   = bus.dmem_wdata;
            if (bus.imem_req && starve_q != SLIM)
              starve_d = starve_q + 1'b1;
          end
          gnt_i: begin
            state_d  = IMEM_OP;
            addr_d   = bus.imem_addr;
            re_d     = 1'b1;
            wr_d     = 1'b0;
            din_d    = '0;
            starve_d = '0;
          end
          default: ;
        endcase
      end
      IMEM_OP, DMEM_OP: begin
        if (done || abort) begin
          state_d = IDLE;
          addr_d  = '0;
          re_d    = 1'b0;
          wr_d    = 1'b0;
          din_d   = '0;
          if (state_q == IMEM_OP) begin
            iack_d   = 1'b1;
            irdata_d = done ? bus.data_out : '0;
          end else begin
            dack_d   = 1'b1;
            drdata_d = (done && !wr_q) ? bus.data_out : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      re_q     <= 1'b0;
      wr_q     <= 1'b0;
      din_q    <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      re_q     <= re_d;
      wr_q     <= wr_d;
      din_q    <= din_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      iack_q   <= iack_d;
      dack_q   <= dack_d;
    end
  end

  assign bus.mem_addr      = addr_q;
  assign bus.en_ext_mem_re = re_q;
  assign bus.en_ext_mem_wr = wr_q;
  assign bus.data_in       = din_q;
  assign bus.imem_rdata    = irdata_q;
  assign bus.dmem_rdata    = drdata_q;
  assign bus.imem_ack      = iack_q;
  assign bus.dmem_ack      = dack_q;
  assign bus.busy          = in_op;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Randomized scoreboard bench for ext_mem_arbiter.
// Inputs change on negedge; model at posedge+1, ack monitor at posedge+2.
`timescale 1ns/1ps
module tb_ext_mem_arbiter;
  localparam int W  = 32;
  localparam int SL = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ext_mem_arbiter_if #(.WORD_SIZE(W)) bus ();

  ext_mem_arbiter #(
    .WORD_SIZE(W),
    .STARVE_LIMIT(SL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int          who;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   mon_en = 0;

  logic [31:0] mem [logic [31:0]];
  int  force_dly = 0;
  bit  spurious = 1;
  bit  rsp_act = 0;
  int  rsp_cnt = 0;

  bit          m_idle = 1;
  int          m_who = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_din = 0;
  logic        m_re = 0;
  logic        m_wr = 0;
  int          scnt = 0;
  int          ocnt = 0;
  bit          pk_i = 0;
  bit          pk_d = 0;
  logic [31:0] last_i = 0;
  logic [31:0] last_d = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // External memory: random latency, stores writes on completion.
  always @(negedge clk) begin
    if (!rst) begin
      rsp_act = 0;
      bus.mem_ready = 0;
    end else if (bus.en_ext_mem_re || bus.en_ext_mem_wr) begin
      if (!rsp_act) begin
        rsp_act = 1;
        rsp_cnt = (force_dly > 0) ? force_dly - 1
                                  : $urandom_range(0, 5);
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
      end
      bus.mem_ready = (rsp_cnt == 0);
      if (rsp_cnt == 0) begin
        rsp_act = 0;
        if (bus.en_ext_mem_wr) mem[bus.mem_addr] = bus.data_in;
      end
      bus.data_out = mem_rd(bus.mem_addr);
    end else begin
      rsp_act = 0;
      bus.mem_ready = spurious && ($urandom_range(0, 7) == 0);
      bus.data_out = $urandom;
    end
  end

  task automatic model_reset();
    m_idle = 1; m_who = 0;
    m_addr = 0; m_din = 0; m_re = 0; m_wr = 0;
    scnt = 0; ocnt = 0; pk_i = 0; pk_d = 0;
    last_i = 0; last_d = 0;
    exp_q.delete();
  endtask

  // Reference: one transaction at a time, grants from request rules.
  task automatic model_step();
    bit   ei, ed, nk_i, nk_d, fin;
    int   g;
    exp_t e;
    nk_i = 0; nk_d = 0; fin = 0; g = 0;
    e.who = 0; e.rdata = 0; e.err = 0;
    if (m_idle) begin
      ei = bus.imem_req && !pk_i;
      ed = bus.dmem_req && !pk_d;
      if (ei && ed) g = (SL != 0 && scnt == SL) ? 1 : 2;
      else if (ed) g = 2;
      else if (ei) g = 1;
      if (g == 2 && bus.imem_req && scnt < SL) scnt++;
      if (g == 1) begin
        scnt = 0; m_idle = 0; m_who = 1; ocnt = 0;
        m_addr = bus.imem_addr; m_re = 1; m_wr = 0; m_din = 0;
      end
      if (g == 2) begin
        m_idle = 0; m_who = 2; ocnt = 0;
        m_addr = bus.dmem_addr;
        m_re = !bus.dmem_we; m_wr = bus.dmem_we;
        m_din = bus.dmem_wdata;
      end
    end else begin
      if (bus.mem_ready) begin
        fin = 1;
        e.rdata = (m_who == 2 && m_wr) ? 32'h0 : mem_rd(m_addr);
      end
`ifdef ARB_TIMEOUT_EN
      else begin
        ocnt++;
        if (ocnt == TO) begin fin = 1; e.err = 1; end
      end
`endif
      if (fin) begin
        e.who = m_who;
        exp_q.push_back(e);
        if (m_who == 1) nk_i = 1; else nk_d = 1;
        m_idle = 1; m_addr = 0; m_din = 0; m_re = 0; m_wr = 0;
      end
    end
    pk_i = nk_i;
    pk_d = nk_d;
    chk("en_ext_mem_re", bus.en_ext_mem_re, m_re);
    chk("en_ext_mem_wr", bus.en_ext_mem_wr, m_wr);
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("data_in", bus.data_in, m_din);
    chk("busy", bus.busy, !m_idle);
  endtask

  task automatic ack_step();
    exp_t e;
    logic xerr;
    xerr = 0;
    chk("dual_ack", bus.imem_ack & bus.dmem_ack, 0);
    if (bus.imem_ack || bus.dmem_ack) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_ack: ack=1, required no ack");
      end else begin
        e = exp_q.pop_front();
        chk("ack_who", bus.imem_ack ? 1 : 2, e.who);
        if (e.who == 1) last_i = e.rdata;
        else last_d = e.rdata;
        xerr = e.err;
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL missing_ack: ack=0, required ack from %0d", e.who);
    end
    chk("imem_rdata", bus.imem_rdata, last_i);
    chk("dmem_rdata", bus.dmem_rdata, last_d);
    chk("err", bus.err, xerr);
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) model_step();
  end

  always @(posedge clk) begin
    #2;
    if (mon_en) ack_step();
  end

  task automatic chk_zero(string tag);
    chk({tag, "_imem_ack"}, bus.imem_ack, 0);
    chk({tag, "_dmem_ack"}, bus.dmem_ack, 0);
    chk({tag, "_imem_rdata"}, bus.imem_rdata, 0);
    chk({tag, "_dmem_rdata"}, bus.dmem_rdata, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_re"}, bus.en_ext_mem_re, 0);
    chk({tag, "_wr"}, bus.en_ext_mem_wr, 0);
    chk({tag, "_data_in"}, bus.data_in, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_err"}, bus.err, 0);
  endtask

  task automatic wait_ack(input int who);
    int n;
    n = 0;
    while (n < 300) begin
      @(posedge clk); #3;
      if (who == 1 && bus.imem_ack) break;
      if (who == 2 && bus.dmem_ack) break;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL ack_timeout: no ack from %0d in 300 cycles", who);
    end
    @(negedge clk);
    if (who == 1) begin
      bus.imem_req = 0;
      bus.imem_addr = $urandom;
    end else begin
      bus.dmem_req = 0;
      bus.dmem_addr = $urandom;
      bus.dmem_wdata = $urandom;
    end
  endtask

  task automatic drive_i(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      bus.imem_req = 1;
      bus.imem_addr = 32'($urandom_range(0, 15)) << 2;
      wait_ack(1);
    end
  endtask

  task automatic drive_d(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      bus.dmem_req = 1;
      bus.dmem_we = 1'($urandom_range(0, 1));
      bus.dmem_addr = 32'($urandom_range(0, 15)) << 2;
      bus.dmem_wdata = $urandom;
      wait_ack(2);
    end
  endtask

  initial begin
    int n;
    rst = 1;
    bus.imem_req = 1; bus.imem_addr = 32'h100;
    bus.dmem_req = 0; bus.dmem_we = 0;
    bus.dmem_addr = 0; bus.dmem_wdata = 0;
    bus.mem_ready = 0; bus.data_out = 0;
    mem[32'h100] = 32'hDEADBEEF;
    #2 rst = 0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");

    // Release: imem granted on the next edge, 3-cycle memory latency.
    force_dly = 3;
    @(negedge clk);
    rst = 1;
    model_reset();
    mon_en = 1;
    wait_ack(1);
    force_dly = 0;

    // Simultaneous requests: dmem write first, then imem.
    @(negedge clk);
    bus.dmem_req = 1; bus.dmem_we = 1;
    bus.dmem_addr = 32'h2000; bus.dmem_wdata = 32'h12345678;
    bus.imem_req = 1; bus.imem_addr = 32'h40;
    fork
      wait_ack(2);
      wait_ack(1);
    join
    @(negedge clk);
    bus.dmem_req = 1; bus.dmem_we = 0; bus.dmem_addr = 32'h2000;
    wait_ack(2);

    // Reset in the middle of a dmem op.
    force_dly = 20;
    @(negedge clk);
    bus.dmem_req = 1; bus.dmem_we = 1;
    bus.dmem_addr = 32'h3000; bus.dmem_wdata = 32'hCAFEF00D;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #3;
      if (bus.busy) break;
      n++;
    end
    chk("busy_before_reset", bus.busy, 1);
    mon_en = 0;
    rst = 0;
    #1 chk_zero("midop");
    bus.dmem_req = 0;
    repeat (2) @(negedge clk);
    chk_zero("midop_hold");
    force_dly = 0;
    @(negedge clk);
    rst = 1;
    model_reset();
    mon_en = 1;
    repeat (5) @(posedge clk);

    fork
      drive_i(40);
      drive_d(40);
    join

`ifdef ARB_TIMEOUT_EN
    spurious = 0;
    force_dly = 1000;
    @(negedge clk);
    bus.imem_req = 1; bus.imem_addr = 32'h80;
    wait_ack(1);
    force_dly = 8;
    @(negedge clk);
    bus.dmem_req = 1; bus.dmem_we = 0; bus.dmem_addr = 32'h84;
    wait_ack(2);
    force_dly = 0;
    spurious = 1;
`endif

    repeat (5) @(posedge clk);
    #3 chk("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
